player_char: RTL and testbench
==============================

# player_char

Parametrised player-character engine for the map/VGA pipeline: registers a movement command, applies speed-divided, bounds-clamped movement with collision blocking, and tracks hit points with invincibility frames. During the draw phase it raster-scans the walk or attack sprite, emitting sprite-sheet addresses and screen coordinates. The coordinates are delay-matched to the external sprite memory's read latency. It sits between the top-level control FSM, the collision detector and the VGA writer, and supersedes the fixed 16x16, 6-HP character block.

## Interface
- TILE, 16: sprite edge in pixels, power of two, 8..32
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- SPEED_DIV, 16: apply_action pulses per move tick, power of two, >=1
- STEP, 1: pixels moved per move tick
- X_MIN/X_MAX, 0/304: legal x_pos range, inclusive
- Y_MIN/Y_MAX, 0/224: legal y_pos range, inclusive
- START_X/START_Y, 1/96: spawn position
- HP_MAX, 6: hp after reset/init, <=7
- INV_TICKS, 15: move ticks of invincibility after a hit, <=15
- MEM_LAT, 1: sprite-memory read latency in cycles, 0..3
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- c_attack, c_up, c_down, c_left, c_right  in  1 each  user commands
- init, reg_action, apply_action, draw  in  1 each  control-FSM phase strobes, mutually exclusive
- collision  in  4  [0] move blocked; [3:1] damage sources
- x_pos / y_pos  out  X_W / Y_W  character top-left position
- direction  out  3  registered command: 0 none, 1 attack, 2 up, 3 down, 4 left, 5 right
- facing  out  3  last movement direction, codes 2..5
- sprite_x / sprite_y  out  clog2(4*TILE) each  sprite-sheet address to external memory
- x_draw / y_draw  out  X_W / Y_W  pixel screen coordinate, aligned with memory colour
- pixel_valid  out  1  x_draw/y_draw valid, aligned with memory colour
- draw_done  out  1  frame finished
- hp  out  3  hit points
- invincible  out  1  invincibility counter nonzero
- dead  out  1  hp == 0

## Operation
- reset or init: x_pos=START_X, y_pos=START_Y, facing=3, direction=0, hp=HP_MAX, inv counter=0, apply counter=0, pixel counter=0, pipeline cleared. All outputs are 0 except the listed values; sprite_x/y=0; draw_done=0.
- reg_action: direction latched with priority attack > up > down > left > right, else 0.
- apply_action: the apply counter increments and wraps at SPEED_DIV. A move tick occurs when the counter was 0 on this pulse.
- Move tick:
  - Inv counter decrements if nonzero.
  - For directions 2..5, facing is updated even when blocked.
  - Position changes by STEP unless collision[0]=1 or dead=1. The result is clamped to [MIN,MAX] with no wrap-around.
  - Attack and none leave position and facing unchanged.
- Damage:
  - Evaluated every cycle except reset/init.
  - When collision[3:1]!=0 and the inv counter is 0 and hp!=0: hp decrements by 1 and the counter loads INV_TICKS.
  - hp saturates at 0.
  - reset/init override damage in the same cycle.
- Sprite origin, in TILE units (col,row):
  - Walk: down (0,0), left (1,0), up (2,0), right (3,0).
  - Invincible walk: same columns, row 3.
  - Attack: down (0,1), left (1,1), up (3,1), right (1,2).
- Draw frame:
  - Attack mode is latched on the first draw cycle.
  - Walk frames scan TILE x TILE pixels. Attack frames scan TILE wide x 2*TILE tall for up/down, and 2*TILE wide x TILE tall for left/right.
  - Scan order is raster, x fastest.
  - Attack up draws at y_pos-TILE. Attack left draws at x_pos-TILE. Arithmetic is modulo 2^W.
- draw deasserted mid-frame: the pixel counter returns to 0 and in-flight pipeline valids are flushed. The next draw restarts the frame.

## Timing
- In the n-th draw cycle of a frame (n from 0), sprite_x/y present pixel n.
- pixel_valid and the matching x_draw/y_draw appear MEM_LAT+1 cycles after that draw cycle edge, aligned with the memory's colour output.
- draw_done rises the cycle after the last pixel_valid. It stays high while draw stays high and clears the cycle after draw falls.
- No pixels are emitted while draw_done=1.
- A walk frame takes TILE*TILE+MEM_LAT+1 cycles to draw_done. An attack frame takes 2*TILE*TILE+MEM_LAT+1.
- Position, facing, hp and invincible update on the edge of the qualifying strobe. dead follows hp combinationally.

## Test plan
- reset, then reg_action with c_up=1, then 32 apply_action pulses with defaults: y_pos 96->94, facing=2, moves only on pulses 1 and 17.
- x_pos=1, command left, three move ticks: x_pos 1->0->0->0, no wrap to 511. Repeat with collision[0]=1 from the start: position unchanged, facing=4.
- collision[3:1]=3'b010 held for 20 cycles: hp 6->5 once, invincible=1. After 15 move ticks invincible=0 and the next hit gives hp=4. Six spaced hits give hp=0 and dead=1, after which movement is ignored.
- Walk draw, facing down, at (1,96), MEM_LAT=1: exactly 256 pixel_valid. First x/y_draw is (1,96), last is (16,111). sprite_x/y spans 0..15/0..15. draw_done rises in cycle 258 and holds until draw falls.
- Attack draw, facing left, at (40,50): 512 pixels. x_draw spans 24..55, y_draw spans 50..65. sprite_x starts at 16, sprite_y at 16.
- draw dropped after 100 cycles, then reasserted: no draw_done in the first attempt. The second frame starts at pixel 0 and completes 256 pixels. Also: reset asserted mid-frame clears pixel_valid and draw_done next cycle.

Source files
------------

// File: rtl/player_char.sv
// player_char: player-character engine for the map/VGA pipeline.
//
// Holds the character position, facing, registered command, hit points and
// invincibility timer, and during the draw phase raster-scans the walk or
// attack sprite, issuing sprite-sheet addresses and the matching screen
// coordinates delayed to line up with the sprite memory's colour output.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   c_attack..c_right             user commands, sampled on reg_action
//   init                          restart: same effect as reset
//   reg_action                    latch the prioritised command into direction
//   apply_action                  advance the speed divider, move on its wrap
//   draw                          scan the sprite while high
//   collision[0]                  movement blocked
//   collision[3:1]                damage sources
//   x_pos, y_pos                  character top-left position
//   direction                     0 none, 1 attack, 2 up, 3 down, 4 left, 5 right
//   facing                        last movement direction (2..5)
//   sprite_x, sprite_y            sprite-sheet address to external memory
//   x_draw, y_draw, pixel_valid   screen pixel, aligned with memory colour
//   draw_done                     frame finished, held while draw stays high
//   hp, invincible, dead          health state
module player_char #(
  parameter int TILE      = 16,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int SPEED_DIV = 16,
  parameter int STEP      = 1,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 304,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 224,
  parameter int START_X   = 1,
  parameter int START_Y   = 96,
  parameter int HP_MAX    = 6,
  parameter int INV_TICKS = 15,
  parameter int MEM_LAT   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      c_attack,
  input  logic                      c_up,
  input  logic                      c_down,
  input  logic                      c_left,
  input  logic                      c_right,
  input  logic                      init,
  input  logic                      reg_action,
  input  logic                      apply_action,
  input  logic                      draw,
  input  logic [3:0]                collision,
  output logic [X_W-1:0]            x_pos,
  output logic [Y_W-1:0]            y_pos,
  output logic [2:0]                direction,
  output logic [2:0]                facing,
  output logic [$clog2(4*TILE)-1:0] sprite_x,
  output logic [$clog2(4*TILE)-1:0] sprite_y,
  output logic [X_W-1:0]            x_draw,
  output logic [Y_W-1:0]            y_draw,
  output logic                      pixel_valid,
  output logic                      draw_done,
  output logic [2:0]                hp,
  output logic                      invincible,
  output logic                      dead
);

  localparam int SW   = $clog2(4*TILE);
  localparam int TB   = $clog2(TILE);
  localparam int PW   = TB + 1;
  localparam int AC_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_ATK   = 3'd1;
  localparam logic [2:0] D_UP    = 3'd2;
  localparam logic [2:0] D_DOWN  = 3'd3;
  localparam logic [2:0] D_LEFT  = 3'd4;
  localparam logic [2:0] D_RIGHT = 3'd5;

  localparam logic [X_W:0] LX_MIN  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] LX_MAX  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] LX_STEP = (X_W+1)'(STEP);
  localparam logic [Y_W:0] LY_MIN  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] LY_MAX  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] LY_STEP = (Y_W+1)'(STEP);

  // ---------------------------------------------------------------- state
  logic [X_W-1:0]  r_x;
  logic [Y_W-1:0]  r_y;
  logic [2:0]      r_dir;
  logic [2:0]      r_facing;
  logic [2:0]      r_hp;
  logic [3:0]      r_inv;
  logic [AC_W-1:0] r_apply;

  logic [2:0]      w_dir_cmd;
  logic            w_tick;
  logic [AC_W-1:0] w_apply_nxt;
  logic            w_dead;
  logic            w_hit;
  logic [X_W:0]    w_x_inc;
  logic [X_W-1:0]  w_x_dec;
  logic [Y_W:0]    w_y_inc;
  logic [Y_W-1:0]  w_y_dec;
  logic [X_W-1:0]  w_x_nxt;
  logic [Y_W-1:0]  w_y_nxt;

  always_comb begin
    if (c_attack)     w_dir_cmd = D_ATK;
    else if (c_up)    w_dir_cmd = D_UP;
    else if (c_down)  w_dir_cmd = D_DOWN;
    else if (c_left)  w_dir_cmd = D_LEFT;
    else if (c_right) w_dir_cmd = D_RIGHT;
    else              w_dir_cmd = D_NONE;
  end

  // A move tick is the apply pulse that finds the divider at zero.
  assign w_tick      = apply_action && (r_apply == '0);
  assign w_apply_nxt = (r_apply == AC_W'(SPEED_DIV-1)) ? '0 : r_apply + 1'b1;
  assign w_dead      = (r_hp == 3'd0);
  assign w_hit       = (|collision[3:1]) && (r_inv == 4'd0) && !w_dead;

  // Increments are computed one bit wider so overflow past the top of the
  // coordinate space clamps instead of wrapping; decrements are guarded by
  // the compare against MIN+STEP before use.
  assign w_x_inc = {1'b0, r_x} + LX_STEP;
  assign w_x_dec = r_x - X_W'(STEP);
  assign w_y_inc = {1'b0, r_y} + LY_STEP;
  assign w_y_dec = r_y - Y_W'(STEP);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    case (r_dir)
      D_UP:    w_y_nxt = ({1'b0, r_y} >= LY_MIN + LY_STEP) ? w_y_dec : LY_MIN[Y_W-1:0];
      D_DOWN:  w_y_nxt = (w_y_inc <= LY_MAX) ? w_y_inc[Y_W-1:0] : LY_MAX[Y_W-1:0];
      D_LEFT:  w_x_nxt = ({1'b0, r_x} >= LX_MIN + LX_STEP) ? w_x_dec : LX_MIN[X_W-1:0];
      D_RIGHT: w_x_nxt = (w_x_inc <= LX_MAX) ? w_x_inc[X_W-1:0] : LX_MAX[X_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || init) begin
      r_x      <= X_W'(START_X);
      r_y      <= Y_W'(START_Y);
      r_dir    <= D_NONE;
      r_facing <= D_DOWN;
      r_hp     <= 3'(HP_MAX);
      r_inv    <= 4'd0;
      r_apply  <= '0;
    end else begin
      if (reg_action)   r_dir   <= w_dir_cmd;
      if (apply_action) r_apply <= w_apply_nxt;
      if (w_tick && (r_dir >= D_UP) && (r_dir <= D_RIGHT)) begin
        r_facing <= r_dir;
        if (!collision[0] && !w_dead) begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
        end
      end
      // A hit needs the timer at zero, so it never coincides with a decrement.
      if (w_hit) begin
        r_hp  <= r_hp - 3'd1;
        r_inv <= 4'(INV_TICKS);
      end else if (w_tick && (r_inv != 4'd0)) begin
        r_inv <= r_inv - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------- draw scan
  logic          r_in_frame;
  logic          r_atk;
  logic          r_all;
  logic          r_done;
  logic [PW-1:0] r_px;
  logic [PW-1:0] r_py;

  logic          w_atk;
  logic          w_horiz;
  logic [PW-1:0] w_px_last;
  logic [PW-1:0] w_py_last;
  logic          w_end_row;
  logic          w_end_frame;
  logic [1:0]    w_col;
  logic [1:0]    w_row;
  logic [SW-1:0] w_sx;
  logic [SW-1:0] w_sy;
  logic [X_W-1:0] w_ox;
  logic [Y_W-1:0] w_oy;
  logic [X_W-1:0] w_dx;
  logic [Y_W-1:0] w_dy;

  // On the first draw cycle the mode comes straight from direction; after
  // that the latched copy keeps the frame shape stable.
  assign w_atk       = r_in_frame ? r_atk : (r_dir == D_ATK);
  assign w_horiz     = (r_facing == D_LEFT) || (r_facing == D_RIGHT);
  assign w_px_last   = (w_atk && w_horiz)  ? PW'(2*TILE-1) : PW'(TILE-1);
  assign w_py_last   = (w_atk && !w_horiz) ? PW'(2*TILE-1) : PW'(TILE-1);
  assign w_end_row   = (r_px == w_px_last);
  assign w_end_frame = w_end_row && (r_py == w_py_last);

  always_comb begin
    w_col = 2'd0;
    w_row = 2'd0;
    if (w_atk) begin
      case (r_facing)
        D_LEFT:  begin w_col = 2'd1; w_row = 2'd1; end
        D_UP:    begin w_col = 2'd3; w_row = 2'd1; end
        D_RIGHT: begin w_col = 2'd1; w_row = 2'd2; end
        default: begin w_col = 2'd0; w_row = 2'd1; end
      endcase
    end else begin
      case (r_facing)
        D_LEFT:  w_col = 2'd1;
        D_UP:    w_col = 2'd2;
        D_RIGHT: w_col = 2'd3;
        default: w_col = 2'd0;
      endcase
      w_row = (r_inv != 4'd0) ? 2'd3 : 2'd0;
    end
  end

  assign w_sx = {w_col, {TB{1'b0}}} + SW'(r_px);
  assign w_sy = {w_row, {TB{1'b0}}} + SW'(r_py);
  assign w_ox = (w_atk && (r_facing == D_LEFT)) ? r_x - X_W'(TILE) : r_x;
  assign w_oy = (w_atk && (r_facing == D_UP))   ? r_y - Y_W'(TILE) : r_y;
  assign w_dx = w_ox + X_W'(r_px);
  assign w_dy = w_oy + Y_W'(r_py);

  logic [SW-1:0]  r_sx_p0;
  logic [SW-1:0]  r_sy_p0;
  logic           r_vld_p  [0:MEM_LAT];
  logic           r_last_p [0:MEM_LAT];
  logic [X_W-1:0] r_xd_p   [0:MEM_LAT];
  logic [Y_W-1:0] r_yd_p   [0:MEM_LAT];

  always_ff @(posedge clock) begin
    if (reset || init) begin
      r_in_frame <= 1'b0;
      r_atk      <= 1'b0;
      r_all      <= 1'b0;
      r_done     <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_sx_p0    <= '0;
      r_sy_p0    <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_last_p[i] <= 1'b0;
        r_xd_p[i]   <= '0;
        r_yd_p[i]   <= '0;
      end
    end else if (!draw) begin
      r_in_frame <= 1'b0;
      r_all      <= 1'b0;
      r_done     <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_last_p[i] <= 1'b0;
      end
    end else begin
      r_in_frame <= 1'b1;
      if (!r_in_frame) r_atk <= (r_dir == D_ATK);
      r_done <= r_done | (r_vld_p[MEM_LAT] & r_last_p[MEM_LAT]);
      // p0: sprite address goes out to memory, screen coordinate enters the
      // delay line alongside it
      r_vld_p[0]  <= !r_all;
      r_last_p[0] <= !r_all && w_end_frame;
      if (!r_all) begin
        r_sx_p0   <= w_sx;
        r_sy_p0   <= w_sy;
        r_xd_p[0] <= w_dx;
        r_yd_p[0] <= w_dy;
        if (w_end_frame) begin
          r_all <= 1'b1;
        end else if (w_end_row) begin
          r_px <= '0;
          r_py <= r_py + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end
      // p1..pMEM_LAT: match the memory read latency
      for (int i = 1; i <= MEM_LAT; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_last_p[i] <= r_last_p[i-1];
        r_xd_p[i]   <= r_xd_p[i-1];
        r_yd_p[i]   <= r_yd_p[i-1];
      end
    end
  end

  assign x_pos       = r_x;
  assign y_pos       = r_y;
  assign direction   = r_dir;
  assign facing      = r_facing;
  assign hp          = r_hp;
  assign invincible  = (r_inv != 4'd0);
  assign dead        = w_dead;
  assign sprite_x    = r_sx_p0;
  assign sprite_y    = r_sy_p0;
  assign x_draw      = r_xd_p[MEM_LAT];
  assign y_draw      = r_yd_p[MEM_LAT];
  assign pixel_valid = r_vld_p[MEM_LAT];
  assign draw_done   = r_done;

endmodule

// File: tb/tb_player_char.sv
module tb_player_char;

  logic       clock = 1'b0;
  logic       reset, c_attack, c_up, c_down, c_left, c_right;
  logic       init, reg_action, apply_action, draw;
  logic [3:0] collision;
  logic [8:0] x_pos, x_draw;
  logic [7:0] y_pos, y_draw;
  logic [2:0] direction, facing, hp;
  logic [5:0] sprite_x, sprite_y;
  logic       pixel_valid, draw_done, invincible, dead;

  player_char dut (
    .clock(clock), .reset(reset), .c_attack(c_attack), .c_up(c_up), .c_down(c_down),
    .c_left(c_left), .c_right(c_right), .init(init), .reg_action(reg_action),
    .apply_action(apply_action), .draw(draw), .collision(collision),
    .x_pos(x_pos), .y_pos(y_pos), .direction(direction), .facing(facing),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .x_draw(x_draw), .y_draw(y_draw),
    .pixel_valid(pixel_valid), .draw_done(draw_done), .hp(hp),
    .invincible(invincible), .dead(dead)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; int sx; int sy; } pix_t;
  pix_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int pix_cnt = 0;
  int prev_sx = 0;
  int prev_sy = 0;

  // Monitor: the colour for a pixel arrives one cycle after its address, so
  // the address seen on the previous cycle belongs to the current pixel.
  always @(negedge clock) begin
    if (pixel_valid) begin
      pix_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL pixel_unexpected: got (%0d,%0d) spr (%0d,%0d), no pixel expected",
                 x_draw, y_draw, prev_sx, prev_sy);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (int'(x_draw) == e.x && int'(y_draw) == e.y && prev_sx == e.sx && prev_sy == e.sy)
          n_pass++;
        else
          $display("FAIL pixel: got xy (%0d,%0d) spr (%0d,%0d), expected xy (%0d,%0d) spr (%0d,%0d)",
                   x_draw, y_draw, prev_sx, prev_sy, e.x, e.y, e.sx, e.sy);
      end
    end
    prev_sx = int'(sprite_x);
    prev_sy = int'(sprite_y);
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [4:0] c);
    {c_attack, c_up, c_down, c_left, c_right} = c;
    reg_action = 1'b1;
    tick();
    reg_action = 1'b0;
    {c_attack, c_up, c_down, c_left, c_right} = 5'b0;
  endtask

  task automatic apply(input int n);
    for (int i = 0; i < n; i++) begin
      apply_action = 1'b1;
      tick();
    end
    apply_action = 1'b0;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic hit_once(input logic [3:0] c);
    collision = c;
    tick();
    collision = 4'd0;
  endtask

  task automatic push_frame(input int x0, input int y0, input int w, input int h,
                            input int sx0, input int sy0);
    for (int py = 0; py < h; py++)
      for (int px = 0; px < w; px++) begin
        pix_t p;
        p.x  = (x0 + px) & 511;
        p.y  = (y0 + py) & 255;
        p.sx = sx0 + px;
        p.sy = sy0 + py;
        exp_q.push_back(p);
      end
  endtask

  // Raises draw and returns the first cycle draw_done was seen (-1 if never)
  // and its value on the last cycle; draw is left high.
  task automatic run_draw(input int ncyc, output int done_cyc, output int done_last);
    draw = 1'b1;
    done_cyc = -1;
    done_last = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (draw_done && done_cyc < 0) done_cyc = c;
      done_last = int'(draw_done);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pv [6];
    int         pe [6];
    int dc, dl;

    reset = 1'b1; init = 1'b0; reg_action = 1'b0; apply_action = 1'b0; draw = 1'b0;
    {c_attack, c_up, c_down, c_left, c_right} = 5'b0;
    collision = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_x", x_pos, 1);
    chk("rst_y", y_pos, 96);
    chk("rst_facing", facing, 3);
    chk("rst_dir", direction, 0);
    chk("rst_hp", hp, 6);
    chk("rst_inv", invincible, 0);
    chk("rst_dead", dead, 0);
    chk("rst_pv", pixel_valid, 0);
    chk("rst_done", draw_done, 0);
    chk("rst_sprite", {sprite_x, sprite_y}, 0);

    // Command priority: {attack,up,down,left,right}
    pv[0] = 5'b11010; pe[0] = 1;
    pv[1] = 5'b01100; pe[1] = 2;
    pv[2] = 5'b00101; pe[2] = 3;
    pv[3] = 5'b00011; pe[3] = 4;
    pv[4] = 5'b00001; pe[4] = 5;
    pv[5] = 5'b00000; pe[5] = 0;
    for (int i = 0; i < 6; i++) begin
      cmd(pv[i]);
      chk($sformatf("prio_%0d", i), direction, pe[i]);
    end
    chk("prio_no_move", x_pos, 1);

    // Up with speed divider: moves on pulses 1 and 17 only
    cmd(5'b01000);
    apply(1);
    chk("up_p1", y_pos, 95);
    chk("up_facing", facing, 2);
    apply(15);
    chk("up_p16", y_pos, 95);
    apply(1);
    chk("up_p17", y_pos, 94);
    apply(15);
    chk("up_p32", y_pos, 94);

    // Left clamp at X_MIN
    cmd(5'b00010);
    apply(16);
    chk("left_t1", x_pos, 0);
    apply(16);
    chk("left_t2", x_pos, 0);
    apply(16);
    chk("left_t3", x_pos, 0);
    chk("left_facing", facing, 4);

    // Blocked by collision[0]
    do_init();
    chk("init_x", x_pos, 1);
    chk("init_y", y_pos, 96);
    chk("init_facing", facing, 3);
    chk("init_dir", direction, 0);
    cmd(5'b00010);
    collision = 4'b0001;
    apply(48);
    collision = 4'd0;
    chk("blk_x", x_pos, 1);
    chk("blk_facing", facing, 4);

    // Down and right
    cmd(5'b00100);
    apply(16);
    chk("down_y", y_pos, 97);
    chk("down_facing", facing, 3);
    cmd(5'b00001);
    apply(16);
    chk("right_x", x_pos, 2);

    // Damage and invincibility
    do_init();
    collision = 4'b0100;
    for (int i = 0; i < 20; i++) tick();
    collision = 4'd0;
    chk("hit1_hp", hp, 5);
    chk("hit1_inv", invincible, 1);
    apply(224);
    chk("inv_14ticks", invincible, 1);
    apply(1);
    chk("inv_15ticks", invincible, 0);
    hit_once(4'b0010);
    chk("hit2_hp", hp, 4);
    chk("hit2_inv", invincible, 1);
    for (int k = 3; k >= 0; k--) begin
      apply(256);
      hit_once(4'b1000);
      chk($sformatf("hit_hp_%0d", k), hp, k);
    end
    chk("dead", dead, 1);
    apply(256);
    hit_once(4'b1110);
    chk("hp_sat", hp, 0);
    chk("dead_no_inv", invincible, 0);
    cmd(5'b00001);
    apply(64);
    chk("dead_no_move", x_pos, 1);

    // Walk frame, facing down at (1,96)
    do_init();
    chk("reinit_hp", hp, 6);
    push_frame(1, 96, 16, 16, 0, 0);
    pix_cnt = 0;
    run_draw(270, dc, dl);
    chk("walk_done_cycle", dc, 258);
    chk("walk_done_held", dl, 1);
    draw = 1'b0;
    tick();
    chk("walk_done_clear", draw_done, 0);
    chk("walk_pix_cnt", pix_cnt, 256);
    chk("walk_q_empty", exp_q.size(), 0);

    // Attack frame, facing left at (40,50)
    do_init();
    cmd(5'b00001);
    apply(16*40);
    cmd(5'b01000);
    apply(16*46);
    cmd(5'b00010);
    apply(16);
    cmd(5'b10000);
    chk("atk_x", x_pos, 40);
    chk("atk_y", y_pos, 50);
    chk("atk_facing", facing, 4);
    chk("atk_dir", direction, 1);
    push_frame(24, 50, 32, 16, 16, 16);
    pix_cnt = 0;
    run_draw(530, dc, dl);
    chk("atk_done_cycle", dc, 514);
    chk("atk_done_held", dl, 1);
    draw = 1'b0;
    tick();
    chk("atk_pix_cnt", pix_cnt, 512);
    chk("atk_q_empty", exp_q.size(), 0);

    // Aborted frame then full restart
    do_init();
    push_frame(1, 96, 16, 16, 0, 0);
    pix_cnt = 0;
    run_draw(100, dc, dl);
    draw = 1'b0;
    tick(); tick(); tick();
    chk("abort_no_done", dc, -1);
    chk("abort_partial", int'(pix_cnt >= 90 && pix_cnt <= 100), 1);
    exp_q.delete();
    push_frame(1, 96, 16, 16, 0, 0);
    pix_cnt = 0;
    run_draw(270, dc, dl);
    chk("restart_done_cycle", dc, 258);
    chk("restart_pix_cnt", pix_cnt, 256);

    // Reset while done is held, then reset mid-frame
    reset = 1'b1;
    tick();
    chk("rst_done_clear", draw_done, 0);
    reset = 1'b0;
    draw = 1'b0;
    tick();
    push_frame(1, 96, 16, 16, 0, 0);
    draw = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("mid_pv_before", pixel_valid, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_pv", pixel_valid, 0);
    chk("mid_rst_done", draw_done, 0);
    reset = 1'b0;
    draw = 1'b0;
    tick();
    exp_q.delete();
    chk("mid_rst_pv_after", pixel_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
